// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand/result handshake bundle
// for the nibble-serial adder, sized by NIBBLES.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
) ();
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    logic         busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, s, co, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, s, co, ovf, busy
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit adder rippling one 4-bit slice
// per cycle, LSB first, behind valid/ready on both sides.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    if (NIBBLES < 2 || NIBBLES > 8) begin : g_bad_param
        $error("NIBBLES must be in 2..8");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_s;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic          r_co;
    logic          r_ovf;
    logic          r_out_valid;
    logic          r_in_ready;
    logic          r_busy;

    logic [IW+1:0] w_lo;
    logic [3:0]    w_a_nib;
    logic [3:0]    w_b_nib;
    logic [4:0]    w_slice;

    assign w_lo    = {r_idx, 2'b00};
    assign w_a_nib = r_a[w_lo +: 4];
    assign w_b_nib = r_b[w_lo +: 4];
    assign w_slice = {1'b0, w_a_nib} + {1'b0, w_b_nib}
                   + {4'b0000, r_carry};

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.s         = r_s;
    assign bus.co        = r_co;
    assign bus.ovf       = r_ovf;
    assign bus.busy      = r_busy;

    // Control FSM and datapath; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_co        <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_carry    <= bus.cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_s[w_lo +: 4] <= w_slice[3:0];
                    r_carry        <= w_slice[4];
                    if (r_idx == LAST) begin
                        // carry into MSB is a^b^s at bit W-1
                        r_co        <= w_slice[4];
                        r_ovf       <= r_a[W-1] ^ r_b[W-1]
                                     ^ w_slice[3] ^ w_slice[4];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed scenarios on a 4-nibble
// adder plus a random stall sweep on 2- and 8-nibble copies.
`timescale 1ns/1ps
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.NIBBLES(4)) if4 ();
    nibble_serial_adder_if #(.NIBBLES(2)) if2 ();
    nibble_serial_adder_if #(.NIBBLES(8)) if8 ();

    nibble_serial_adder #(.NIBBLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4.slave)
    );
    nibble_serial_adder #(.NIBBLES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave)
    );
    nibble_serial_adder #(.NIBBLES(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8.slave)
    );

    logic        rv[2];
    logic        rrdy[2];
    logic        rcin[2];
    logic [31:0] ra[2];
    logic [31:0] rb[2];
    logic [31:0] os[2];
    logic        oco[2];
    logic        oovf[2];
    logic        ovalid[2];
    logic        oready[2];

    assign if2.in_valid  = rv[0];
    assign if2.out_ready = rrdy[0];
    assign if2.cin       = rcin[0];
    assign if2.a         = ra[0][7:0];
    assign if2.b         = rb[0][7:0];
    assign if8.in_valid  = rv[1];
    assign if8.out_ready = rrdy[1];
    assign if8.cin       = rcin[1];
    assign if8.a         = ra[1];
    assign if8.b         = rb[1];
    assign os[0]     = {24'b0, if2.s};
    assign oco[0]    = if2.co;
    assign oovf[0]   = if2.ovf;
    assign ovalid[0] = if2.out_valid;
    assign oready[0] = if2.in_ready;
    assign os[1]     = if8.s;
    assign oco[1]    = if8.co;
    assign oovf[1]   = if8.ovf;
    assign ovalid[1] = if8.out_valid;
    assign oready[1] = if8.in_ready;

    task automatic run4(
        input  logic [15:0] a,
        input  logic [15:0] b,
        input  logic        cin,
        output logic [15:0] s,
        output logic        co,
        output logic        ovf,
        output int          lat
    );
        int n;
        @(negedge clk);
        if4.a = a;
        if4.b = b;
        if4.cin = cin;
        if4.out_ready = 1'b0;
        if4.in_valid = 1'b1;
        n = 0;
        while (!if4.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 if4.in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (if4.out_valid) break;
        end
        s = if4.s;
        co = if4.co;
        ovf = if4.ovf;
    endtask

    task automatic handoff4();
        if4.out_ready = 1'b1;
        @(posedge clk);
        #1 if4.out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if4.in_valid = 1'b1;
        if4.a = 16'h1111;
        if4.b = 16'h2222;
        if4.cin = 1'b1;
        if4.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({if4.out_valid, if4.busy, if4.in_ready,
             if4.s, if4.co, if4.ovf} !== {3'b001, 16'h0, 2'b00}) begin
            errors++;
            $display("FAIL reset_state got ov/bz/ir=%b%b%b s=%h co=%b ovf=%b want 001 0000 0 0",
                     if4.out_valid, if4.busy, if4.in_ready,
                     if4.s, if4.co, if4.ovf);
        end
        if4.in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({if4.busy, if4.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_release got busy=%b in_ready=%b want 0 1",
                     if4.busy, if4.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [15:0] va[4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [15:0] vb[4] = '{16'h4321, 16'h0000, 16'h0001, 16'h8000};
        logic        vc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] es[4] = '{16'h5555, 16'h0000, 16'h8000, 16'h0000};
        logic        ec[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        eo[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] s;
        logic        co, ovf;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run4(va[i], vb[i], vc[i], s, co, ovf, lat);
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL basic_latency[%0d] got %0d want 4", i, lat);
            end
            checks++;
            if (s !== es[i]) begin
                errors++;
                $display("FAIL basic_sum[%0d] got %h want %h", i, s, es[i]);
            end
            checks++;
            if (co !== ec[i]) begin
                errors++;
                $display("FAIL basic_co[%0d] got %b want %b", i, co, ec[i]);
            end
            checks++;
            if (ovf !== eo[i]) begin
                errors++;
                $display("FAIL basic_ovf[%0d] got %b want %b", i, ovf, eo[i]);
            end
            handoff4();
            checks++;
            if ({if4.out_valid, if4.in_ready, if4.busy} !== 3'b010) begin
                errors++;
                $display("FAIL basic_handoff[%0d] got ov/ir/bz=%b%b%b want 010",
                         i, if4.out_valid, if4.in_ready, if4.busy);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] s;
        logic        co, ovf;
        int          lat;
        run4(16'h0F0F, 16'h0101, 1'b1, s, co, ovf, lat);
        checks++;
        if ({s, co, ovf} !== {16'h1011, 2'b00}) begin
            errors++;
            $display("FAIL stall_result got s=%h co=%b ovf=%b want 1011 0 0",
                     s, co, ovf);
        end
        if4.a = 16'hAAAA;
        if4.b = 16'h5555;
        if4.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({if4.out_valid, if4.in_ready, if4.busy,
                 if4.s, if4.co, if4.ovf} !== {3'b101, 16'h1011, 2'b00}) begin
                errors++;
                $display("FAIL stall_hold[%0d] got ov/ir/bz=%b%b%b s=%h co=%b ovf=%b want 101 1011 0 0",
                         i, if4.out_valid, if4.in_ready, if4.busy,
                         if4.s, if4.co, if4.ovf);
            end
        end
        if4.in_valid = 1'b0;
        handoff4();
        @(negedge clk);
        checks++;
        if ({if4.busy, if4.out_valid, if4.s} !== {2'b00, 16'h1011}) begin
            errors++;
            $display("FAIL stall_after got busy=%b ov=%b s=%h want 0 0 1011",
                     if4.busy, if4.out_valid, if4.s);
        end
    endtask

    task automatic test_back_to_back();
        int   n, t1, t2;
        logic prev;
        @(negedge clk);
        if4.out_ready = 1'b1;
        if4.a = 16'h1111;
        if4.b = 16'h2222;
        if4.cin = 1'b0;
        if4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if4.a = 16'hF000;
        if4.b = 16'h1000;
        n = 0;
        t1 = -1;
        t2 = -1;
        prev = 1'b0;
        while (t2 < 0 && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (if4.busy && !if4.out_valid && t1 >= 0)
                if4.in_valid = 1'b0;
            if (if4.out_valid && !prev) begin
                if (t1 < 0) begin
                    t1 = n;
                    checks++;
                    if ({if4.s, if4.co, if4.ovf} !== {16'h3333, 2'b00}) begin
                        errors++;
                        $display("FAIL b2b_first got s=%h co=%b ovf=%b want 3333 0 0",
                                 if4.s, if4.co, if4.ovf);
                    end
                end else begin
                    t2 = n;
                    checks++;
                    if ({if4.s, if4.co, if4.ovf} !== {16'h0000, 2'b10}) begin
                        errors++;
                        $display("FAIL b2b_second got s=%h co=%b ovf=%b want 0000 1 0",
                                 if4.s, if4.co, if4.ovf);
                    end
                end
            end
            prev = if4.out_valid;
        end
        if4.in_valid = 1'b0;
        checks++;
        if (t1 !== 4) begin
            errors++;
            $display("FAIL b2b_latency got %0d want 4", t1);
        end
        checks++;
        if (t2 - t1 !== 6) begin
            errors++;
            $display("FAIL b2b_period got %0d want 6", t2 - t1);
        end
        @(negedge clk);
        if4.out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [15:0] s;
        logic        co, ovf, seen;
        int          lat;
        @(negedge clk);
        if4.a = 16'h1234;
        if4.b = 16'h1111;
        if4.cin = 1'b0;
        if4.out_ready = 1'b0;
        if4.in_valid = 1'b1;
        @(posedge clk);
        #1 if4.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if4.busy, if4.s} !== {1'b1, 16'h0045}) begin
            errors++;
            $display("FAIL abort_midcalc got busy=%b s=%h want 1 0045",
                     if4.busy, if4.s);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if4.out_valid, if4.busy, if4.in_ready,
             if4.s, if4.co, if4.ovf} !== {3'b001, 16'h0, 2'b00}) begin
            errors++;
            $display("FAIL abort_reset got ov/bz/ir=%b%b%b s=%h co=%b ovf=%b want 001 0000 0 0",
                     if4.out_valid, if4.busy, if4.in_ready,
                     if4.s, if4.co, if4.ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (if4.out_valid || if4.busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_result got activity=%b want 0", seen);
        end
        run4(16'h00FF, 16'h0001, 1'b0, s, co, ovf, lat);
        checks++;
        if ({s, co, ovf, lat} !== {16'h0100, 2'b00, 32'd4}) begin
            errors++;
            $display("FAIL abort_next got s=%h co=%b ovf=%b lat=%0d want 0100 0 0 4",
                     s, co, ovf, lat);
        end
        handoff4();
    endtask

    task automatic sweep(input int k, input int nib, input int count);
        int          w, n;
        logic [31:0] mask, ea, eb, es;
        logic [32:0] full;
        logic        ec, eco, eovf, got;
        w = 4 * nib;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        for (int t = 0; t < count; t++) begin
            @(negedge clk);
            rrdy[k] = 1'b0;
            rv[k] = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ea = $urandom & mask;
            eb = $urandom & mask;
            ec = 1'($urandom_range(0, 1));
            ra[k] = ea;
            rb[k] = eb;
            rcin[k] = ec;
            rv[k] = 1'b1;
            n = 0;
            while (!oready[k] && n < 40) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1 rv[k] = 1'b0;
            full = {1'b0, ea} + {1'b0, eb} + {32'b0, ec};
            es = full[31:0] & mask;
            eco = full[w];
            eovf = (ea[w-1] == eb[w-1]) && (es[w-1] != ea[w-1]);
            got = 1'b0;
            n = 0;
            while (n < 60) begin
                @(negedge clk);
                n++;
                if (ovalid[k]) begin
                    if (!got) begin
                        got = 1'b1;
                        checks++;
                        if ({oco[k], oovf[k], os[k]} !== {eco, eovf, es}) begin
                            errors++;
                            $display("FAIL sweep_n%0d[%0d] a=%h b=%h cin=%b got s=%h co=%b ovf=%b want s=%h co=%b ovf=%b",
                                     nib, t, ea, eb, ec, os[k], oco[k],
                                     oovf[k], es, eco, eovf);
                        end
                    end
                    rrdy[k] = ($urandom_range(0, 2) != 0);
                    if (rrdy[k]) begin
                        @(posedge clk);
                        break;
                    end
                end else begin
                    rrdy[k] = 1'($urandom_range(0, 1));
                end
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL sweep_n%0d[%0d] timeout got no out_valid want one", nib, t);
            end
        end
        @(negedge clk);
        rrdy[k] = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rv[k] = 1'b0;
            rrdy[k] = 1'b0;
            rcin[k] = 1'b0;
            ra[k] = '0;
            rb[k] = '0;
        end
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_abort();
        fork
            sweep(0, 2, 2000);
            sweep(1, 8, 2000);
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
